// File: rtl/fp12_pkg.sv
// Shared definitions for the 12-bit float format and the acc_12 reduction FSM.
// Format: sign[11], exponent[10:6] (bias 15), mantissa[5:0]. Zero is all zeros.
package fp12_pkg;
   localparam int SGN    = 11;
   localparam int EXP_HI = 10;
   localparam int EXP_LO = 6;
   localparam int MAN_HI = 5;
   localparam int MAN_LO = 0;

   localparam logic [11:0] FP12_ZERO = 12'h000;
   localparam int          ADD_LAT   = 5;

   // Counter marks: last flush slot, and the cycles where issued sums come back.
   localparam logic [2:0] CNT_LAST = 3'(ADD_LAT - 1);
   localparam logic [2:0] CNT_RET0 = 3'(ADD_LAT);
   localparam logic [2:0] CNT_RET1 = 3'(ADD_LAT + 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_ACCUM, ST_FLUSH, ST_RED1, ST_RED2, ST_RED3, ST_DONE
   } state_t;
endpackage

// File: rtl/add_12.sv
// Pipelined 12-bit float adder: round-to-nearest-even, denormals flushed to zero,
// magnitude saturating at exponent 31. Result appears ADD_LAT cycles after the inputs.
module add_12
   import fp12_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [11:0] a_i,
   input  logic [11:0] b_i,
   output logic [11:0] y_o
);
   logic [10:0]              w_ka, w_kb;
   logic [11:0]              w_big, w_sml;
   logic [4:0]               w_d;
   logic [9:0]               w_mb, w_ms, w_ms_al;
   logic                     w_stk;
   logic [10:0]              w_sum;
   logic [9:0]               w_norm;
   logic [3:0]               w_lz;
   logic                     w_found, w_up;
   logic [7:0]               w_rnd;
   logic signed [7:0]        w_e;
   logic [11:0]              w_res;
   logic [ADD_LAT-1:0][11:0] r_pipe;

   // Magnitude keys: a zero exponent (zero or denormal) counts as zero.
   assign w_ka = (a_i[EXP_HI:EXP_LO] == '0) ? '0 : a_i[EXP_HI:MAN_LO];
   assign w_kb = (b_i[EXP_HI:EXP_LO] == '0) ? '0 : b_i[EXP_HI:MAN_LO];

   always_comb begin
      w_big   = (w_kb > w_ka) ? b_i : a_i;
      w_sml   = (w_kb > w_ka) ? a_i : b_i;
      w_mb    = (w_big[EXP_HI:EXP_LO] == '0) ? '0 : {1'b1, w_big[MAN_HI:MAN_LO], 3'b000};
      w_ms    = (w_sml[EXP_HI:EXP_LO] == '0) ? '0 : {1'b1, w_sml[MAN_HI:MAN_LO], 3'b000};
      w_d     = w_big[EXP_HI:EXP_LO] - w_sml[EXP_HI:EXP_LO];
      // Three guard bits plus a sticky LSB keep the RNE decision exact.
      w_stk   = |(w_ms & ((10'd1 << w_d) - 10'd1));
      w_ms_al = (w_ms >> w_d) | {9'd0, w_stk};
      w_sum   = (w_big[SGN] ^ w_sml[SGN]) ? ({1'b0, w_mb} - {1'b0, w_ms_al})
                                          : ({1'b0, w_mb} + {1'b0, w_ms_al});
      w_e     = $signed({3'b000, w_big[EXP_HI:EXP_LO]});
      w_lz    = '0;
      w_found = 1'b0;
      for (int i = 9; i >= 0; i--) begin
         if (!w_found) begin
            if (w_sum[i]) w_found = 1'b1;
            else          w_lz    = w_lz + 4'd1;
         end
      end
      if (w_sum[10]) begin
         w_norm = {w_sum[10:2], |w_sum[1:0]};
         w_e    = w_e + 8'sd1;
      end else begin
         w_norm = w_sum[9:0] << w_lz;
         w_e    = w_e - $signed({4'b0000, w_lz});
      end
      w_up  = w_norm[2] & (w_norm[3] | (|w_norm[1:0]));
      w_rnd = {1'b0, w_norm[9:3]} + {7'd0, w_up};
      if (w_rnd[7]) w_e = w_e + 8'sd1;
      if (w_sum == '0)        w_res = FP12_ZERO;
      else if (w_e > 8'sd31)  w_res = {w_big[SGN], 11'h7FF};
      else if (w_e < 8'sd1)   w_res = FP12_ZERO;
      else                    w_res = {w_big[SGN], w_e[4:0], w_rnd[5:0]};
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) r_pipe <= '0;
      else          r_pipe <= {r_pipe[ADD_LAT-2:0], w_res};
   end

   assign y_o = r_pipe[ADD_LAT-1];
endmodule

// File: rtl/acc_12.sv
// Streaming fp12 sum: five interleaved partials live in the add_12 pipeline,
// then a flush/reduce sequence folds them into one result.
module acc_12
   import fp12_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [11:0] data_i,
   input  logic        valid_i,
   input  logic        last_i,
   output logic        ready_o,
   output logic [11:0] sum_o,
   output logic        sum_valid_o,
   output logic        busy_o
);
   state_t                   r_state;
   logic [2:0]               r_cnt;
   logic [ADD_LAT-1:0][11:0] r_p;
   logic [11:0]              r_q0, r_q1, r_sum;
   logic                     r_sum_valid;
   logic [11:0]              w_add_a, w_add_b, w_add_y;
   logic                     w_accept;

   assign ready_o     = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
   assign busy_o      = (r_state != ST_IDLE);
   assign w_accept    = valid_i && ready_o;
   assign sum_o       = r_sum;
   assign sum_valid_o = r_sum_valid;

   // Any slot not issuing real work feeds 0/0 so the pipeline drains to zero.
   always_comb begin
      w_add_a = FP12_ZERO;
      w_add_b = FP12_ZERO;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_add_a = data_i;
               w_add_b = w_add_y;
            end
         end
         ST_ACCUM: begin
            w_add_a = w_accept ? data_i : FP12_ZERO;
            w_add_b = w_add_y;
         end
         ST_RED1: begin
            if (r_cnt == 3'd0) begin
               w_add_a = r_p[0];
               w_add_b = r_p[1];
            end else if (r_cnt == 3'd1) begin
               w_add_a = r_p[2];
               w_add_b = r_p[3];
            end
         end
         ST_RED2: begin
            if (r_cnt == 3'd0) begin
               w_add_a = r_q0;
               w_add_b = r_q1;
            end
         end
         ST_RED3: begin
            // r is forwarded straight from the adder output as it returns.
            if (r_cnt == 3'd0) begin
               w_add_a = w_add_y;
               w_add_b = r_p[ADD_LAT-1];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_p         <= '0;
         r_q0        <= '0;
         r_q1        <= '0;
         r_sum       <= '0;
         r_sum_valid <= 1'b0;
      end else begin
         r_sum_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_cnt   <= '0;
                  r_state <= last_i ? ST_FLUSH : ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (w_accept && last_i) begin
                  r_cnt   <= '0;
                  r_state <= ST_FLUSH;
               end
            end
            ST_FLUSH: begin
               r_p[r_cnt] <= w_add_y;
               if (r_cnt == CNT_LAST) begin
                  r_cnt   <= '0;
                  r_state <= ST_RED1;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            ST_RED1: begin
               r_cnt <= r_cnt + 3'd1;
               if (r_cnt == CNT_RET0) r_q0 <= w_add_y;
               if (r_cnt == CNT_RET1) begin
                  r_q1    <= w_add_y;
                  r_cnt   <= '0;
                  r_state <= ST_RED2;
               end
            end
            ST_RED2: begin
               if (r_cnt == CNT_LAST) begin
                  r_cnt   <= '0;
                  r_state <= ST_RED3;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            ST_RED3: begin
               if (r_cnt == CNT_RET0) begin
                  r_sum       <= w_add_y;
                  r_sum_valid <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   add_12 u_add (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .a_i     (w_add_a),
      .b_i     (w_add_b),
      .y_o     (w_add_y)
   );
endmodule

// File: tb/tb_acc_12.sv
// Directed table plus hand sequences for acc_12; random vectors use a
// real-arithmetic fp12 model summed in the same lane order as the hardware.
module tb_acc_12;
   logic        clk = 1'b0;
   logic        rst_n_i;
   logic [11:0] data_i;
   logic        valid_i, last_i;
   logic        ready_o, sum_valid_o, busy_o;
   logic [11:0] sum_o;

   int total = 0;
   int bad   = 0;
   int strobes = 0;

   logic [11:0] v_smp [64];
   int          v_gap [64];
   int          v_n;

   typedef struct {
      string       name;
      int          n;
      logic [11:0] s [10];
      int          g [10];
      logic [11:0] e;
   } vec_t;

   vec_t tbl [10];

   acc_12 dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n_i),
      .data_i      (data_i),
      .valid_i     (valid_i),
      .last_i      (last_i),
      .ready_o     (ready_o),
      .sum_o       (sum_o),
      .sum_valid_o (sum_valid_o),
      .busy_o      (busy_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (sum_valid_o) strobes++;

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic real f2r(input logic [11:0] x);
      real v;
      int  e;
      if (x[10:6] == 5'd0) return 0.0;
      v = 1.0 + real'(int'(x[5:0])) / 64.0;
      e = int'(x[10:6]) - 15;
      while (e > 0) begin v = v * 2.0; e--; end
      while (e < 0) begin v = v / 2.0; e++; end
      return x[11] ? -v : v;
   endfunction

   function automatic logic [11:0] r2f(input real v);
      logic s;
      real  a, f, fl;
      int   e, m;
      logic [4:0] eb;
      logic [5:0] mb;
      if (v == 0.0) return 12'h000;
      s = (v < 0.0);
      a = s ? -v : v;
      e = 15;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      f  = a * 64.0;
      fl = $floor(f);
      m  = int'(fl);
      if ((f - fl > 0.5) || ((f - fl == 0.5) && (m % 2 == 1))) m++;
      if (m == 128) begin m = 64; e++; end
      if (e > 31) return {s, 11'h7FF};
      if (e < 1)  return 12'h000;
      eb = 5'(e);
      mb = 6'(m);
      return {s, eb, mb};
   endfunction

   function automatic logic [11:0] m_add(input logic [11:0] a, input logic [11:0] b);
      return r2f(f2r(a) + f2r(b));
   endfunction

   // Up to three distinct samples; samples beyond the third repeat c.
   function automatic vec_t mk(input string nm, input int n, input logic [11:0] a,
                               input logic [11:0] b, input logic [11:0] c,
                               input int gb, input int gc, input logic [11:0] e);
      vec_t t;
      t.name = nm;
      t.n    = n;
      t.e    = e;
      for (int i = 0; i < 10; i++) begin
         t.s[i] = (i == 0) ? a : (i == 1) ? b : c;
         t.g[i] = (i == 1) ? gb : (i == 2) ? gc : 0;
      end
      return t;
   endfunction

   // Bubble cycles drive last_i=1 with junk data: both must be ignored.
   task automatic send_vec(input bit hold, input logic [11:0] hdata);
      int w;
      for (int i = 0; i < v_n; i++) begin
         if (i > 0) begin
            for (int k = 0; k < v_gap[i]; k++) begin
               valid_i = 1'b0; last_i = 1'b1; data_i = 12'($urandom);
               step();
            end
         end
         valid_i = 1'b1; data_i = v_smp[i]; last_i = (i == v_n - 1);
         w = 0;
         while (!ready_o && w < 100) begin step(); w++; end
         if (w >= 100) chk("send_ready_timeout", 32'(w), 32'(0));
         step();
      end
      if (hold) begin valid_i = 1'b1; data_i = hdata; last_i = 1'b1; end
      else      begin valid_i = 1'b0; data_i = 12'h000; last_i = 1'b0; end
   endtask

   // Called at T+1; n is the cycle offset from T at which the strobe is seen.
   task automatic wait_strobe(output logic [11:0] s, output int n, output int rlow);
      n = 1; rlow = 0; s = 12'h000;
      while (n < 60) begin
         if (!ready_o) rlow++;
         if (sum_valid_o) begin s = sum_o; break; end
         step();
         n++;
      end
   endtask

   function automatic logic [11:0] lane_model();
      logic [11:0] lane [5];
      logic [11:0] p [5];
      logic [11:0] q0, q1, r;
      int slot, t;
      for (int i = 0; i < 5; i++) lane[i] = 12'h000;
      slot = 0;
      for (int i = 0; i < v_n; i++) begin
         if (i > 0) slot += v_gap[i];
         lane[slot % 5] = m_add(v_smp[i], lane[slot % 5]);
         slot++;
      end
      t = slot - 1;
      for (int k = 0; k < 5; k++) p[k] = lane[(t + 1 + k) % 5];
      q0 = m_add(p[0], p[1]);
      q1 = m_add(p[2], p[3]);
      r  = m_add(q0, q1);
      return m_add(r, p[4]);
   endfunction

   initial begin
      logic [11:0] s, e;
      int n, rl, sc, bl;

      tbl[0] = mk("one",      1, 12'h3C0, 12'h000, 12'h000, 0, 0, 12'h3C0);
      tbl[1] = mk("ten",     10, 12'h3C0, 12'h3C0, 12'h3C0, 0, 0, 12'h490);
      tbl[2] = mk("cancel",   2, 12'h3C0, 12'hBC0, 12'h000, 0, 0, 12'h000);
      tbl[3] = mk("bubbles",  3, 12'h3C0, 12'h400, 12'h380, 1, 2, 12'h430);
      tbl[4] = mk("tie_even", 2, 12'h3C0, 12'h3C1, 12'h000, 0, 0, 12'h400);
      tbl[5] = mk("tie_up",   2, 12'h3C0, 12'h3C3, 12'h000, 0, 0, 12'h402);
      tbl[6] = mk("sat",      2, 12'h7FF, 12'h7FF, 12'h000, 0, 0, 12'h7FF);
      tbl[7] = mk("flush",    2, 12'h041, 12'h840, 12'h000, 0, 0, 12'h000);
      tbl[8] = mk("align",    2, 12'h3C0, 12'h340, 12'h000, 0, 0, 12'h3D0);
      tbl[9] = mk("neg",      3, 12'hBC0, 12'hBC0, 12'hC00, 0, 0, 12'hC40);

      rst_n_i = 1'b0; valid_i = 1'b0; last_i = 1'b0; data_i = 12'h000;
      step(); step();
      chk("rst_sum",   32'(sum_o), 32'h000);
      chk("rst_valid", 32'(sum_valid_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_busy",  32'(busy_o), 32'd0);
      rst_n_i = 1'b1;
      step();

      // Single sample: timing, busy window, one strobe, held result.
      v_n = 1; v_smp[0] = 12'h3C0; v_gap[0] = 0;
      sc = strobes;
      send_vec(1'b0, 12'h000);
      bl = 0;
      for (int k = 1; k <= 24; k++) begin
         if (!busy_o) bl++;
         if (k < 24) step();
      end
      chk("one_busy_low_cycles", 32'(bl), 32'd0);
      chk("one_strobe_T24",      32'(sum_valid_o), 32'd1);
      chk("one_sum",             32'(sum_o), 32'h3C0);
      step();
      chk("one_busy_T25",  32'(busy_o), 32'd0);
      chk("one_ready_T25", 32'(ready_o), 32'd1);
      chk("one_valid_T25", 32'(sum_valid_o), 32'd0);
      chk("one_sum_held",  32'(sum_o), 32'h3C0);
      step();
      chk("one_strobe_count", 32'(strobes - sc), 32'd1);

      for (int t = 0; t < 10; t++) begin
         v_n = tbl[t].n;
         for (int i = 0; i < v_n; i++) begin
            v_smp[i] = tbl[t].s[i];
            v_gap[i] = tbl[t].g[i];
         end
         send_vec(1'b0, 12'h000);
         wait_strobe(s, n, rl);
         chk($sformatf("%s_sum", tbl[t].name), 32'(s), 32'(tbl[t].e));
         chk($sformatf("%s_lat", tbl[t].name), 32'(n), 32'd24);
      end

      // Sample held on valid_i through the busy window is taken only at T+25.
      v_n = 3;
      v_smp[0] = 12'h3C0; v_smp[1] = 12'h400; v_smp[2] = 12'h380;
      v_gap[0] = 0; v_gap[1] = 1; v_gap[2] = 2;
      send_vec(1'b1, 12'h420);
      wait_strobe(s, n, rl);
      chk("hold_sum",       32'(s), 32'h430);
      chk("hold_lat",       32'(n), 32'd24);
      chk("hold_ready_low", 32'(rl), 32'd24);
      step();
      chk("hold_ready_T25", 32'(ready_o), 32'd1);
      step();
      valid_i = 1'b0; last_i = 1'b0; data_i = 12'h000;
      wait_strobe(s, n, rl);
      chk("hold_next_sum", 32'(s), 32'h420);
      chk("hold_next_lat", 32'(n), 32'd24);
      step();

      // Reset during RED2 aborts with no strobe; next vector is clean.
      v_n = 3;
      for (int i = 0; i < 3; i++) begin v_smp[i] = 12'h3C0; v_gap[i] = 0; end
      send_vec(1'b0, 12'h000);
      for (int k = 0; k < 14; k++) step();
      chk("red2_busy", 32'(busy_o), 32'd1);
      sc = strobes;
      rst_n_i = 1'b0;
      #1;
      chk("mid_rst_sum",   32'(sum_o), 32'h000);
      chk("mid_rst_valid", 32'(sum_valid_o), 32'd0);
      chk("mid_rst_ready", 32'(ready_o), 32'd1);
      chk("mid_rst_busy",  32'(busy_o), 32'd0);
      step(); step();
      rst_n_i = 1'b1;
      for (int k = 0; k < 30; k++) step();
      chk("mid_rst_no_strobe", 32'(strobes - sc), 32'd0);
      v_n = 1; v_smp[0] = 12'h420; v_gap[0] = 0;
      send_vec(1'b0, 12'h000);
      wait_strobe(s, n, rl);
      chk("post_rst_sum", 32'(s), 32'h420);
      chk("post_rst_lat", 32'(n), 32'd24);

      // Random vectors back to back against the lane-ordered model.
      for (int t = 0; t < 15; t++) begin
         v_n = $urandom_range(1, 64);
         for (int i = 0; i < v_n; i++) begin
            v_smp[i] = {1'($urandom_range(0, 1)), 5'($urandom_range(12, 18)),
                        6'($urandom_range(0, 63))};
            v_gap[i] = (i > 0 && $urandom_range(0, 3) == 0) ? 1 : 0;
         end
         e = lane_model();
         send_vec(1'b0, 12'h000);
         wait_strobe(s, n, rl);
         chk($sformatf("rand%0d_n%0d_sum", t, v_n), 32'(s), 32'(e));
         chk($sformatf("rand%0d_lat", t), 32'(n), 32'd24);
      end

      step(); step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
